debounce_sync: RTL
==================

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Upstream conditioning stage: turns a raw asynchronous, bouncing input into a clean, clock-synchronous level and edge pulses that can drive a D flip-flop's D or clear input.

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops; legal range 2..4.
REQ-003 Parameter STABLE_CNT, default 16: number of consecutive identical synchronized samples needed to accept a level change; legal range 2..65535.
REQ-004 Local constant CNT_W SHALL equal clog2(STABLE_CNT).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 clr_n  in  1  asynchronous active-low reset.
REQ-007 din  in  1  raw input, asynchronous to clk, may bounce.
REQ-008 q  out  1  debounced level.
REQ-009 rise  out  1  one-cycle pulse when q goes 0->1.
REQ-010 fall  out  1  one-cycle pulse when q goes 1->0.
REQ-011 busy  out  1  high while a candidate level change is being qualified.

Function
REQ-012 din SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is s, the only signal the FSM samples.
REQ-013 FSM states SHALL be STABLE_LO, QUAL_HI, STABLE_HI and QUAL_LO.
REQ-014 STABLE_LO with s=1 SHALL go to QUAL_HI with cnt=1; with s=0 it SHALL stay in STABLE_LO.
REQ-015 QUAL_HI with s=0 SHALL return to STABLE_LO with cnt=0 (glitch rejected), with no change on q and no pulse on rise or fall.
REQ-016 QUAL_HI with s=1 and cnt=STABLE_CNT-1 SHALL go to STABLE_HI, register q=1, and assert rise for exactly the next cycle.
REQ-017 QUAL_HI with s=1 and cnt<STABLE_CNT-1 SHALL increment cnt.
REQ-018 STABLE_HI, QUAL_LO and fall SHALL mirror REQ-014..017 with the polarities inverted.
REQ-019 Latency SHALL be exactly SYNC_STAGES+STABLE_CNT rising edges from the first edge sampling a stable new din value to the edge that updates q.
REQ-020 busy SHALL be 1 exactly when the state is QUAL_HI or QUAL_LO.
REQ-021 rise and fall SHALL never be high in the same cycle, and q SHALL never toggle twice within STABLE_CNT cycles.
REQ-022 cnt SHALL never exceed STABLE_CNT-1 and SHALL never wrap.
REQ-023 All outputs SHALL be registered, with no combinational path from din.

Reset
REQ-024 clr_n=0 SHALL, without a clock edge, force the synchronizer flops to 0, the state to STABLE_LO, cnt=0, q=0, rise=0, fall=0 and busy=0.
REQ-025 Reset asserted mid-qualification SHALL abandon the qualification with no pulse emitted.
REQ-026 After clr_n deasserts, the first qualification SHALL start at the first rising edge where s=1.

Structure
REQ-027 State encodings SHALL live in the shared package or include file debounce_pkg, alongside the parameter legal-range constants.
REQ-028 The synchronizer chain SHALL be the sub-module bit_synchronizer (parameter STAGES, ports clk, clr_n, d, q); the FSM and counter SHALL be in debounce_sync.

Verification (SYNC_STAGES=2, STABLE_CNT=4)
REQ-029 Clean step: din 0->1 before edge 1 and held -> q=1 after edge 6; rise high for only the cycle after edge 6; busy high after edges 3..5.
REQ-030 Glitch: din high for 3 cycles, then low -> q stays 0, no rise, busy pulses, and the state returns to STABLE_LO.
REQ-031 Bounce: din toggles 1,0,1,1,0,1, then holds 1 -> exactly one rise, 4 edges after the last sampled transition, after the synchronizer delay.
REQ-032 Falling edge: from q=1, din->0 held -> q=0 after 6 edges; single fall pulse; rise stays 0.
REQ-033 Reset mid-qualification: clr_n->0 between clock edges while in QUAL_HI -> q, busy and cnt are 0 immediately; after release with din held at 1 -> rise 6 edges later.
REQ-034 Minimum parameter: STABLE_CNT=2 with a 1-cycle glitch -> rejected; a 2-cycle stable value -> accepted, with q updated 4 edges after din changes.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: qualifier FSM encoding and legal parameter ranges
// shared by the debounce/synchronizer slice.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int STABLE_CNT_MIN  = 2;
    localparam int STABLE_CNT_MAX  = 65535;

    function automatic logic params_legal(
        input int sync_stages,
        input int stable_cnt
    );
        return (sync_stages >= SYNC_STAGES_MIN)
            && (sync_stages <= SYNC_STAGES_MAX)
            && (stable_cnt >= STABLE_CNT_MIN)
            && (stable_cnt <= STABLE_CNT_MAX);
    endfunction

endpackage

// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw input in, clean level and edge pulses out.
// master drives din, slave is the debouncer.
interface debounce_sync_if;
    logic din;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output din,
        input  q,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  din,
        output q,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: STAGES-deep flop chain bringing an asynchronous
// bit into the clk domain; clears to 0.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes din, then accepts a level change only
// after STABLE_CNT identical samples; emits registered q/rise/fall/busy.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 16
) (
    input  logic           clk,
    input  logic           clr_n,
    debounce_sync_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             q_r;
    logic             rise_r;
    logic             fall_r;
    logic             busy_r;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .clr_n (clr_n),
        .d     (bus.din),
        .q     (s)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            q_r    <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            unique case (state)
                STABLE_LO: begin
                    if (s) begin
                        state  <= QUAL_HI;
                        cnt    <= CNT_ONE;
                        busy_r <= 1'b1;
                    end
                end
                QUAL_HI: begin
                    if (!s) begin
                        state  <= STABLE_LO;
                        cnt    <= '0;
                        busy_r <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= STABLE_HI;
                        cnt    <= '0;
                        q_r    <= 1'b1;
                        rise_r <= 1'b1;
                        busy_r <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state  <= QUAL_LO;
                        cnt    <= CNT_ONE;
                        busy_r <= 1'b1;
                    end
                end
                QUAL_LO: begin
                    if (s) begin
                        state  <= STABLE_HI;
                        cnt    <= '0;
                        busy_r <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= STABLE_LO;
                        cnt    <= '0;
                        q_r    <= 1'b0;
                        fall_r <= 1'b1;
                        busy_r <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.rise = rise_r;
    assign bus.fall = fall_r;
    assign bus.busy = busy_r;
endmodule
